charli_scan: RTL and testbench
==============================

Name: charli_scan

Overview:
- Scan controller for the 56-LED Charlieplexed array on the expansion board: 8 tri-state pins, 8 anode rows × 7 cathodes = 56 LEDs.
- Accepts a 56-bit frame from a pattern generator through a valid/ready handshake and double-buffers it.
- Time-multiplexes the frame onto the pins one anode row at a time, with a blanking gap between rows to suppress ghosting.
- Sits between pattern logic and the top-level tri-state pin buffers.

Parameters:
- DWELL, 5000, clock cycles each row is driven (≥1).
- BLANK, 100, clock cycles all pins are high-Z between rows (≥1).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk).
- enable  input  1  scan enable; 0 forces idle.
- frame_in  input  56  LED frame; bit i = LED i, 1 = lit.
- frame_valid  input  1  frame_in is valid.
- frame_ready  output  1  pending buffer empty; frame accepted when valid & ready.
- pin_oe  output  8  per-pin output enable (0 = high-Z).
- pin_out  output  8  per-pin drive level, meaningful where pin_oe = 1.
- row  output  3  current anode row index.
- frame_done  output  1  one-cycle pulse at end of row 7 drive.

Behaviour:
- LED mapping: LED i → r = i/7, c = i%7.
  - Anode pin = r.
  - Cathode pin p = c if c < r, else c+1.
- Registers: active[55:0] (displayed frame), pending[55:0] with pending_v, state, row, dwell/blank counter (width $clog2(max(DWELL,BLANK))).
- Reset (rst = 0 at posedge):
  - state = IDLE, row = 0, active = 0, pending_v = 0.
  - pin_oe = 0, pin_out = 0, frame_done = 0, frame_ready = 0.
  - Reset overrides everything, including mid-row.
- frame_ready is registered:
  - Value = !pending_v of the current cycle.
  - First rises the cycle after rst releases.
- Accept: frame_valid & frame_ready at posedge → pending = frame_in, pending_v = 1.
  - frame_ready falls the next cycle.
  - frame_in is ignored while frame_ready = 0.
- Swap rule (no tearing):
  - pending → active, pending_v = 0, only at either:
    - the DRIVE→BLANK transition leaving row 7, or
    - any cycle in IDLE with pending_v = 1.
  - An accept and a swap are never simultaneous, because ready is low while pending_v = 1.
- FSM:
  - IDLE: outputs high-Z, row = 0. If enable = 1 → BLANK (row 0, counter = 0).
  - BLANK: pin_oe = 0, pin_out = 0. After BLANK cycles in the state → DRIVE, same row.
  - DRIVE, row r:
    - pin_oe[r] = 1, pin_out[r] = 1.
    - For each p ≠ r: pin_oe[p] = active[7r + c(p)], pin_out[p] = 0.
    - After DWELL cycles → BLANK with row = r+1 (7 wraps to 0).
    - Leaving row 7: frame_done = 1 for exactly one cycle, coincident with the first BLANK cycle of row 0; the swap is applied at the same edge.
  - enable = 0 in BLANK/DRIVE → IDLE at the next edge: outputs high-Z, row = 0, counter = 0, no frame_done.
- Outputs are registered and take the new state's values on the same edge as the state change.
- Timing:
  - Row period = BLANK + DWELL.
  - Frame period = 8·(BLANK + DWELL) cycles.
  - First DRIVE cycle occurs BLANK+1 cycles after enable is sampled high in IDLE.
- Electrical invariant: at most one pin has pin_out = 1 at any time, and never while in BLANK/IDLE.

Test Plan (DWELL = 4, BLANK = 2):
- Reset: hold rst = 0 for 3 cycles with frame_valid = 1 → all outputs 0. Release → frame_ready = 1 next cycle, state IDLE.
- Load frame 56'h1 in IDLE, then enable = 1:
  - Row-0 drive: pin_oe = 8'b0000_0011, pin_out = 8'b0000_0001 for 4 cycles.
  - Rows 1–7: pin_oe has only the row bit set.
- Frame 56'h80_0000_0000_0000 (LED 55): row-7 drive → pin_oe = 8'b1100_0000, pin_out = 8'b1000_0000.
- Tearing check:
  - Stimulus: send frame B mid-row 3 while frame A is displayed.
  - Rows 3–7 still show A; B appears from the next row-0 drive.
  - frame_ready is low from the accept until the swap edge.
  - frame_done period = 48 cycles.
- Back-pressure: offer frame C while B is pending → not accepted (ready = 0); C is accepted the cycle after ready returns high.
- Abort cases:
  - Drop enable mid-row 5 → next cycle pin_oe = 0, row = 0, no frame_done.
  - Re-enable → restart at row 0 BLANK.
  - rst = 0 during DRIVE → next cycle all outputs 0 and active = 0.

Source files
------------

// File: rtl/charli_scan.sv
// Charlieplex scan for 8 pins / 56 LEDs: double-buffered frame, row = BLANK+DWELL cycles, outputs registered (1-cycle).
// Backpressure: frame_ready low while a frame is pending; the pending frame is swapped in only at the frame boundary or in idle.
module charli_scan #(
  parameter int DWELL = 5000,
  parameter int BLANK = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [55:0] frame_in,
  input  logic        frame_valid,
  output logic        frame_ready,
  output logic [7:0]  pin_oe,
  output logic [7:0]  pin_out,
  output logic [2:0]  row,
  output logic        frame_done
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [55:0]   active_q, active_d;
  logic [55:0]   pending_q, pending_d;
  logic          pending_v_q, pending_v_d;
  logic          frame_ready_q;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    pin_oe_q, pin_oe_d;
  logic [7:0]    pin_out_q, pin_out_d;
  logic          swap;
  logic          accept;

  // LED index driven as cathode on pin p while anode row r is active.
  function automatic logic [5:0] led_idx(input logic [2:0] r, input logic [2:0] p);
    logic [2:0] c;
    c = (p < r) ? p : p - 3'd1;
    return ({3'b000, r} * 6'd7) + {3'b000, c};
  endfunction

  assign accept = frame_valid && frame_ready_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      row_q         <= 3'd0;
      cnt_q         <= '0;
      active_q      <= '0;
      pending_q     <= '0;
      pending_v_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pin_oe_q      <= '0;
      pin_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      pending_v_q   <= pending_v_d;
      frame_ready_q <= !pending_v_d;
      frame_done_q  <= frame_done_d;
      pin_oe_q      <= pin_oe_d;
      pin_out_q     <= pin_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cnt_d        = cnt_q;
    swap         = 1'b0;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        row_d = 3'd0;
        cnt_d = '0;
        swap  = pending_v_q;
        if (enable) state_d = S_BLANK;
      end
      S_BLANK: begin
        if (!enable) begin
          state_d = S_IDLE;
          row_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d = S_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRIVE: begin
        if (!enable) begin
          state_d = S_IDLE;
          row_d   = 3'd0;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          row_d   = row_q + 3'd1;
          // Frame boundary: the only tear-free point to swap while scanning.
          if (row_q == 3'd7) begin
            frame_done_d = 1'b1;
            swap         = pending_v_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        row_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    active_d    = swap ? pending_q : active_q;
    pending_d   = accept ? frame_in : pending_q;
    pending_v_d = pending_v_q;
    if (accept)    pending_v_d = 1'b1;
    else if (swap) pending_v_d = 1'b0;
  end

  always_comb begin
    pin_oe_d  = '0;
    pin_out_d = '0;
    if (state_d == S_DRIVE) begin
      for (int p = 0; p < 8; p++) begin
        if (p == int'(row_d)) begin
          pin_oe_d[p]  = 1'b1;
          pin_out_d[p] = 1'b1;
        end else begin
          pin_oe_d[p] = active_d[led_idx(row_d, 3'(p))];
        end
      end
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_done  = frame_done_q;
  assign pin_oe      = pin_oe_q;
  assign pin_out     = pin_out_q;
  assign row         = row_q;

endmodule

// File: tb/tb_charli_scan.sv
// Bench for charli_scan: time-position reference model, directed scenarios, then random traffic.
module tb_charli_scan;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int RP = DW + BL;
  localparam int FP = 8 * RP;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [55:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  pin_oe;
  logic [7:0]  pin_out;
  logic [2:0]  row;
  logic        frame_done;

  charli_scan #(.DWELL(DW), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .pin_oe(pin_oe),
    .pin_out(pin_out), .row(row), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: scan position is just a cycle count since the scan started.
  logic        m_on;
  int          m_t;
  logic [55:0] m_act, m_pend;
  logic        m_pv, m_rdy;

  function automatic int m_row();
    return (m_t % FP) / RP;
  endfunction

  function automatic bit m_drive();
    return m_on && ((m_t % FP) % RP) >= BL;
  endfunction

  function automatic logic [55:0] rnd56();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[55:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [7:0] e_oe, e_out;
    int r, c, p;
    e_oe  = '0;
    e_out = '0;
    r = m_on ? m_row() : 0;
    if (m_drive()) begin
      e_oe[r]  = 1'b1;
      e_out[r] = 1'b1;
      for (int i = 0; i < 56; i++) begin
        if (i / 7 == r && m_act[i]) begin
          c = i % 7;
          p = (c < r) ? c : c + 1;
          e_oe[p] = 1'b1;
        end
      end
    end
    chk("pin_oe", pin_oe, e_oe);
    chk("pin_out", pin_out, e_out);
    chk("row", row, r);
    chk("frame_done", frame_done, m_on && m_t > 0 && (m_t % FP) == 0);
    chk("frame_ready", frame_ready, m_rdy);
    chk("single_high", $countones(pin_out) <= 1, 1);
  endtask

  task automatic tick();
    logic acc;
    if (!rst) begin
      m_on = 0; m_t = 0; m_act = '0; m_pv = 0; m_rdy = 0;
    end else begin
      acc = frame_valid && m_rdy;
      if (!m_on) begin
        if (m_pv) begin m_act = m_pend; m_pv = 0; end
        if (enable) begin m_on = 1; m_t = 0; end
      end else if (!enable) begin
        m_on = 0; m_t = 0;
      end else begin
        m_t++;
        if (m_t % FP == 0 && m_pv) begin m_act = m_pend; m_pv = 0; end
      end
      if (acc) begin m_pend = frame_in; m_pv = 1; end
      m_rdy = !m_pv;
    end
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic [55:0] fa, fb, fc;
    logic [55:0] led55;
    bit ok;
    int gap;

    m_on = 0; m_t = 0; m_act = '0; m_pend = '0; m_pv = 0; m_rdy = 0;
    led55 = 56'h80_0000_0000_0000;
    rst = 1'b0; enable = 1'b0; frame_valid = 1'b1; frame_in = rnd56();
    #1;
    repeat (3) tick();
    chk("rst_oe", pin_oe, 8'h00);
    chk("rst_ready", frame_ready, 1'b0);

    rst = 1'b1; frame_valid = 1'b0;
    tick();
    chk("ready_after_rst", frame_ready, 1'b1);

    // Single LED 0 loaded while idle, then scan.
    frame_in = 56'h1; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    enable = 1'b1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      tick();
      ok = m_drive() && m_row() == 0;
    end
    chk("reach_row0", ok, 1);
    chk("row0_oe", pin_oe, 8'b0000_0011);
    chk("row0_out", pin_out, 8'b0000_0001);
    repeat (FP) tick();

    // LED 55 lives on row 7, cathode pin 6.
    frame_in = led55; frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick();
      ok = m_drive() && m_row() == 7 && m_act == led55;
    end
    chk("reach_row7", ok, 1);
    chk("row7_oe", pin_oe, 8'b1100_0000);
    chk("row7_out", pin_out, 8'b1000_0000);

    // Tearing: B arrives mid-row 3 of A; C is offered while B is pending.
    fa = rnd56(); fb = rnd56(); fc = rnd56();
    frame_in = fa; frame_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      ok = m_pv && m_pend == fa;
    end
    chk("accept_a", ok, 1);
    frame_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      tick();
      ok = m_act == fa && m_drive() && m_row() == 3;
    end
    chk("reach_a_row3", ok, 1);
    frame_in = fb; frame_valid = 1'b1;
    tick();
    chk("ready_low_after_b", frame_ready, 1'b0);
    frame_in = fc;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      tick();
      ok = m_pv && m_pend == fc;
    end
    chk("accept_c", ok, 1);
    frame_valid = 1'b0;

    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      tick();
      ok = frame_done;
    end
    chk("done_seen", ok, 1);
    ok = 0; gap = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      tick();
      gap++;
      ok = frame_done;
    end
    chk("done_period", gap, 48);

    // Abort mid-row 5, then restart.
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      tick();
      ok = m_drive() && m_row() == 5;
    end
    chk("reach_row5", ok, 1);
    enable = 1'b0;
    tick();
    chk("abort_oe", pin_oe, 8'h00);
    chk("abort_row", row, 3'd0);
    chk("abort_done", frame_done, 1'b0);
    repeat (3) tick();
    enable = 1'b1;
    repeat (20) tick();

    // Reset during drive.
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      ok = m_drive();
    end
    chk("reach_drive", ok, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_oe", pin_oe, 8'h00);
    chk("mid_rst_ready", frame_ready, 1'b0);
    rst = 1'b1;
    repeat (2 * FP) tick();

    for (int k = 0; k < 1500; k++) begin
      frame_valid = ($urandom_range(0, 3) == 0);
      frame_in    = rnd56();
      enable      = ($urandom_range(0, 127) != 0);
      rst         = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
